// File: rtl/jh_pkg.sv
// Shared JH datapath constants and helpers.
// Used by the source FIFO and the result path.
package jh_pkg;

  localparam int JH_WORD_W = 64;
  localparam int JH_HALF_W = 32;

  function automatic logic [JH_WORD_W-1:0] jh_bswap64(
    input logic [JH_WORD_W-1:0] w
  );
    logic [JH_WORD_W-1:0] r;
    r = '0;
    for (int b = 0; b < 8; b++) begin
      r[8*b +: 8] = w[8*(7-b) +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/jh_src_fifo_mem.sv
// Word storage for the JH source FIFO.
// One write port, one asynchronous read port, no reset on the array.
module jh_src_fifo_mem
  import jh_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic                 clk,
  input  logic                 we_i,
  input  logic [AW-1:0]        waddr_i,
  input  logic [JH_WORD_W-1:0] wdata_i,
  input  logic [AW-1:0]        raddr_i,
  output logic [JH_WORD_W-1:0] rdata_o
);

  logic [JH_WORD_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/jh_src_fifo.sv
// Bus-to-core source FIFO: packs 32-bit writes into 64-bit words.
// Define JH_SRC_BYTESWAP_EN to byte-reverse dout per word.
module jh_src_fifo
  import jh_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 flush,
  input  logic                 wr_lo,
  input  logic                 wr_hi,
  input  logic [JH_HALF_W-1:0] wr_data,
  input  logic                 src_read,
  output logic                 src_ready,
  output logic [JH_WORD_W-1:0] dout,
  output logic [AW:0]          level,
  output logic                 full,
  output logic                 overflow,
  output logic                 underflow
);

  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [AW:0]          level_q, level_d;
  logic [JH_HALF_W-1:0] lo_q, lo_d;
  logic                 ovf_q, ovf_d;
  logic                 unf_q, unf_d;
  logic                 seen_q, seen_d;

  logic                 empty;
  logic                 pop_ok;
  logic                 push_ok;
  logic [JH_WORD_W-1:0] push_word;
  logic [JH_WORD_W-1:0] head;

  assign empty = (level_q == '0);
  assign full  = (level_q == FULL_LVL);

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    level_d   = level_q;
    lo_d      = lo_q;
    ovf_d     = ovf_q;
    unf_d     = unf_q;
    seen_d    = seen_q;
    pop_ok    = src_read && !empty && !flush;
    push_ok   = wr_hi && (!full || pop_ok) && !flush;
    push_word = wr_lo ? {wr_data, wr_data}
                      : {wr_data, lo_q};
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
      lo_d     = '0;
      ovf_d    = 1'b0;
      unf_d    = 1'b0;
      seen_d   = 1'b0;
    end else begin
      if (wr_lo) lo_d = wr_data;
      if (src_read && empty) unf_d = 1'b1;
      if (wr_hi && !push_ok) ovf_d = 1'b1;
      if (pop_ok) rd_ptr_d = rd_ptr_q + 1'b1;
      if (push_ok) begin
        wr_ptr_d = wr_ptr_q + 1'b1;
        seen_d   = 1'b1;
      end
      level_d = level_q
              + {{AW{1'b0}}, push_ok}
              - {{AW{1'b0}}, pop_ok};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      lo_q     <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      seen_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      lo_q     <= lo_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
      seen_q   <= seen_d;
    end
  end

  jh_src_fifo_mem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk     (clk),
    .we_i    (push_ok),
    .waddr_i (wr_ptr_q),
    .wdata_i (push_word),
    .raddr_i (rd_ptr_q),
    .rdata_o (head)
  );

  // Array is unreset; show zero until the first push after reset/flush.
  logic [JH_WORD_W-1:0] word;
  assign word = seen_q ? head : '0;

`ifdef JH_SRC_BYTESWAP_EN
  assign dout = jh_bswap64(word);
`else
  assign dout = word;
`endif

  assign src_ready = empty;
  assign level     = level_q;
  assign overflow  = ovf_q;
  assign underflow = unf_q;

endmodule

// File: tb/tb_jh_src_fifo.sv
// Self-checking bench for jh_src_fifo.
// Table vectors plus hand-written multi-cycle sequences.
module tb_jh_src_fifo;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        flush;
  logic        wr_lo;
  logic        wr_hi;
  logic [31:0] wr_data;
  logic        src_read;
  logic        src_ready;
  logic [63:0] dout;
  logic [4:0]  level;
  logic        full;
  logic        overflow;
  logic        underflow;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  jh_src_fifo #(.DEPTH(16), .AW(4)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .flush     (flush),
    .wr_lo     (wr_lo),
    .wr_hi     (wr_hi),
    .wr_data   (wr_data),
    .src_read  (src_read),
    .src_ready (src_ready),
    .dout      (dout),
    .level     (level),
    .full      (full),
    .overflow  (overflow),
    .underflow (underflow)
  );

  typedef struct {
    logic        fl;
    logic        lo;
    logic        hi;
    logic [31:0] d;
    logic        rd;
    logic        e_rdy;
    logic        chk_dout;
    logic [63:0] e_dout;
    logic [4:0]  e_lvl;
    logic        e_full;
    logic        e_ovf;
    logic        e_unf;
  } vec_t;

  vec_t vec [10];

  function automatic logic [63:0] expo(input logic [63:0] w);
    logic [63:0] r;
`ifdef JH_SRC_BYTESWAP_EN
    for (int b = 0; b < 8; b++) r[8*b +: 8] = w[56-8*b +: 8];
`else
    r = w;
`endif
    return r;
  endfunction

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    flush = 0; wr_lo = 0; wr_hi = 0;
    wr_data = '0; src_read = 0;
  endtask

  task automatic push(input logic [63:0] w);
    idle();
    wr_lo = 1; wr_data = w[31:0];
    tick();
    idle();
    wr_hi = 1; wr_data = w[63:32];
    tick();
    idle();
  endtask

  task automatic do_flush();
    idle();
    flush = 1;
    tick();
    idle();
  endtask

  logic [63:0] q [$];
  logic [63:0] w;

  initial begin
    vec[0] = '{0,1,0,32'h11223344,0, 1,0,64'h0, 0,0,0,0};
    vec[1] = '{0,0,1,32'h55667788,0,
               0,1,64'h5566778811223344, 1,0,0,0};
    vec[2] = '{0,0,1,32'hAAAA0000,0,
               0,1,64'h5566778811223344, 2,0,0,0};
    vec[3] = '{0,1,1,32'hCAFEBABE,0,
               0,1,64'h5566778811223344, 3,0,0,0};
    vec[4] = '{0,0,0,32'h0,1,
               0,1,64'hAAAA000011223344, 2,0,0,0};
    vec[5] = '{0,0,0,32'h0,1,
               0,1,64'hCAFEBABECAFEBABE, 1,0,0,0};
    vec[6] = '{0,0,0,32'h0,1, 1,0,64'h0, 0,0,0,0};
    vec[7] = '{0,0,0,32'h0,1, 1,0,64'h0, 0,0,0,1};
    vec[8] = '{0,0,1,32'h00000001,1,
               0,1,64'h00000001CAFEBABE, 1,0,0,1};
    vec[9] = '{1,0,1,32'h12345678,1, 1,1,64'h0, 0,0,0,0};

    idle();
    reset_n = 0;
    #12;
    chk("rst_ready", 64'(src_ready), 64'd1);
    chk("rst_level", 64'(level), 64'd0);
    chk("rst_full", 64'(full), 64'd0);
    chk("rst_ovf", 64'(overflow), 64'd0);
    chk("rst_unf", 64'(underflow), 64'd0);
    chk("rst_dout", dout, 64'd0);
    reset_n = 1;
    @(negedge clk);

    for (int i = 0; i < 10; i++) begin
      flush = vec[i].fl; wr_lo = vec[i].lo;
      wr_hi = vec[i].hi; wr_data = vec[i].d;
      src_read = vec[i].rd;
      tick();
      chk($sformatf("v%0d_ready", i),
          64'(src_ready), 64'(vec[i].e_rdy));
      chk($sformatf("v%0d_level", i),
          64'(level), 64'(vec[i].e_lvl));
      chk($sformatf("v%0d_full", i),
          64'(full), 64'(vec[i].e_full));
      chk($sformatf("v%0d_ovf", i),
          64'(overflow), 64'(vec[i].e_ovf));
      chk($sformatf("v%0d_unf", i),
          64'(underflow), 64'(vec[i].e_unf));
      if (vec[i].chk_dout)
        chk($sformatf("v%0d_dout", i),
            dout, expo(vec[i].e_dout));
    end
    idle();

    // fill, overflow, drain
    do_flush();
    for (int i = 0; i < 16; i++) push(64'(i));
    chk("fill_full", 64'(full), 64'd1);
    chk("fill_level", 64'(level), 64'd16);
    chk("fill_ovf0", 64'(overflow), 64'd0);
    push(64'h77);
    chk("drop_ovf", 64'(overflow), 64'd1);
    chk("drop_level", 64'(level), 64'd16);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("drain%0d", i), dout, expo(64'(i)));
      src_read = 1;
      tick();
      idle();
    end
    chk("drain_ready", 64'(src_ready), 64'd1);
    chk("drain_level", 64'(level), 64'd0);

    // push and pop together while full
    do_flush();
    chk("flush_ovf", 64'(overflow), 64'd0);
    for (int i = 0; i < 16; i++) push(64'(i + 32));
    wr_lo = 1; wr_data = 32'h64;
    tick();
    idle();
    wr_hi = 1; wr_data = 32'h0; src_read = 1;
    tick();
    idle();
    chk("sim_level", 64'(level), 64'd16);
    chk("sim_head", dout, expo(64'd33));
    chk("sim_ovf", 64'(overflow), 64'd0);
    for (int i = 0; i < 15; i++) begin
      src_read = 1;
      tick();
      idle();
    end
    chk("sim_last", dout, expo(64'h64));
    chk("sim_lvl1", 64'(level), 64'd1);

    // underflow on empty
    do_flush();
    src_read = 1;
    tick();
    idle();
    chk("unf_set", 64'(underflow), 64'd1);
    chk("unf_level", 64'(level), 64'd0);
    push(64'hABCD);
    chk("unf_ptr", dout, expo(64'hABCD));
    do_flush();
    chk("unf_clr", 64'(underflow), 64'd0);

    // pointer wrap with interleaved pops
    q.delete();
    for (int i = 0; i < 20; i++) begin
      w = {32'h0, 32'(i + 200)};
      push(w);
      q.push_back(w);
      chk($sformatf("wrap_lvl%0d", i),
          64'(level), 64'(q.size()));
      if (i % 2 == 1) begin
        chk($sformatf("wrap_pop%0d", i), dout, expo(q[0]));
        void'(q.pop_front());
        src_read = 1;
        tick();
        idle();
      end
    end
    for (int k = 0; k < 20 && q.size() > 0; k++) begin
      chk("wrap_drain", dout, expo(q[0]));
      void'(q.pop_front());
      src_read = 1;
      tick();
      idle();
    end
    chk("wrap_empty", 64'(src_ready), 64'd1);

    // async reset mid-stream
    for (int i = 0; i < 5; i++) push(64'(i + 9));
    chk("pre_rst_lvl", 64'(level), 64'd5);
    reset_n = 0;
    #1;
    chk("arst_level", 64'(level), 64'd0);
    chk("arst_ready", 64'(src_ready), 64'd1);
    @(negedge clk);
    reset_n = 1;
    push(64'hDEADBEEF01234567);
    chk("post_rst", dout, expo(64'hDEADBEEF01234567));
    chk("post_lvl", 64'(level), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
